// File: rtl/controlador_barramento_es_pkg.sv
// Shared constants for the CPU read-bus controller.
// Contents:
//   SEL_*       read-data multiplexer select codes (also used by the mux itself)
//   ST_*        FSM state encodings of controlador_barramento_es
//   GRANT_*     encoding of the round-robin "last grant" register
package controlador_barramento_es_pkg;

   typedef logic [1:0] sel_t;
   typedef logic [1:0] state_t;

   localparam sel_t SEL_OTHER = 2'b00;
   localparam sel_t SEL_DISK  = 2'b01;
   localparam sel_t SEL_INTC  = 2'b10;

   localparam state_t ST_IDLE      = 2'd0;
   localparam state_t ST_INTC_RD   = 2'd1;
   localparam state_t ST_DISK_WAIT = 2'd2;
   localparam state_t ST_DISK_DONE = 2'd3;

   localparam logic GRANT_DISK = 1'b0;
   localparam logic GRANT_INTC = 1'b1;

endpackage

// File: rtl/controlador_barramento_es_contador_timeout_disco.sv
// Saturating timeout counter for disk reads.
// Ports:
//   i_clock    system clock, rising edge
//   i_reset    asynchronous active-high reset
//   i_clear    synchronous clear to zero (has priority over i_enable)
//   i_enable   count one cycle
//   o_expired  counter equals TIMEOUT_CYCLES-1
// The counter stops at TIMEOUT_CYCLES-1, so it can never wrap while enabled.
module contador_timeout_disco #(
   parameter int TIMEOUT_CYCLES = 64,
   parameter int CNT_W          = 8
) (
   input  logic i_clock,
   input  logic i_reset,
   input  logic i_clear,
   input  logic i_enable,
   output logic o_expired
);

   localparam logic [CNT_W-1:0] LIMIT = CNT_W'(TIMEOUT_CYCLES - 1);

   logic [CNT_W-1:0] r_count;
   logic             w_expired;

   assign w_expired = (r_count == LIMIT);
   assign o_expired = w_expired;

   always_ff @(posedge i_clock or posedge i_reset) begin
      if (i_reset) begin
         r_count <= '0;
      end else if (i_clear) begin
         r_count <= '0;
      end else if (i_enable && !w_expired) begin
         r_count <= r_count + 1'b1;
      end
   end

endmodule

// File: rtl/controlador_barramento_es.sv
// CPU read-bus controller: arbitrates and sequences CPU reads from the disk
// and from the interrupt controller, drives the read-data mux select and
// stalls the CPU until the chosen source has valid data.
// Ports:
//   i_clock     system clock, rising edge
//   i_reset     asynchronous active-high reset
//   i_disk_req  disk read requested (level, held while o_stall=1)
//   i_intc_req  INTC read requested (level, held while o_stall=1)
//   i_disk_ack  disk data valid on its bus this cycle
//   i_err_clr   clears o_disk_err
//   o_ctrl      read-data mux select (00 other, 01 disk, 10 INTC)
//   o_disk_rd   disk read strobe
//   o_intc_rd   INTC read strobe (pops the pending-interrupt register)
//   o_stall     freezes the CPU pipeline
//   o_disk_err  sticky disk-timeout flag
//   o_state     current FSM state, for observation
//
// Handshake: a request line is a valid that the CPU holds while o_stall=1;
// o_stall low while o_ctrl selects a source is the "ready" cycle in which the
// CPU samples the read data. Any later request level starts a new read.
module controlador_barramento_es #(
   parameter int TIMEOUT_CYCLES = 64,
   parameter int CNT_W          = 8
) (
   input  logic       i_clock,
   input  logic       i_reset,
   input  logic       i_disk_req,
   input  logic       i_intc_req,
   input  logic       i_disk_ack,
   input  logic       i_err_clr,
   output logic [1:0] o_ctrl,
   output logic       o_disk_rd,
   output logic       o_intc_rd,
   output logic       o_stall,
   output logic       o_disk_err,
   output logic [1:0] o_state
);

   import controlador_barramento_es_pkg::*;

   logic [1:0] r_state;
   logic [1:0] w_next;
   logic       r_last_grant;
   logic       r_disk_err;
   logic       w_grant_intc;
   logic       w_grant_disk;
   logic       w_expired;
   logic       w_timeout;

   // The counter is held at zero while idle, so every disk read starts at 0.
   contador_timeout_disco #(
      .TIMEOUT_CYCLES(TIMEOUT_CYCLES),
      .CNT_W         (CNT_W)
   ) u_contador (
      .i_clock  (i_clock),
      .i_reset  (i_reset),
      .i_clear  (r_state == ST_IDLE),
      .i_enable (r_state == ST_DISK_WAIT),
      .o_expired(w_expired)
   );

   // An ack in the expiry cycle counts as a successful read.
   assign w_timeout = (r_state == ST_DISK_WAIT) && w_expired && !i_disk_ack;

   always_comb begin
      w_next       = r_state;
      w_grant_intc = 1'b0;
      w_grant_disk = 1'b0;
      case (r_state)
         ST_IDLE: begin
            // On a tie, grant the source that was not granted last.
            if (i_intc_req && (!i_disk_req || r_last_grant == GRANT_DISK)) begin
               w_grant_intc = 1'b1;
            end else if (i_disk_req) begin
               w_grant_disk = 1'b1;
            end
            if (w_grant_intc) begin
               w_next = ST_INTC_RD;
            end else if (w_grant_disk) begin
               w_next = ST_DISK_WAIT;
            end
         end
         ST_INTC_RD: w_next = ST_IDLE;
         ST_DISK_WAIT: begin
            if (i_disk_ack || w_expired) begin
               w_next = ST_DISK_DONE;
            end else if (!i_disk_req) begin
               w_next = ST_IDLE;  // CPU flushed the request
            end
         end
         ST_DISK_DONE: w_next = ST_IDLE;
         default:      w_next = ST_IDLE;
      endcase
   end

   always_ff @(posedge i_clock or posedge i_reset) begin
      if (i_reset) begin
         r_state      <= ST_IDLE;
         r_last_grant <= GRANT_DISK;
         r_disk_err   <= 1'b0;
      end else begin
         r_state <= w_next;
         if (w_grant_intc) begin
            r_last_grant <= GRANT_INTC;
         end else if (w_grant_disk) begin
            r_last_grant <= GRANT_DISK;
         end
         // A timeout in the same cycle as err_clr leaves the flag set.
         if (w_timeout) begin
            r_disk_err <= 1'b1;
         end else if (i_err_clr) begin
            r_disk_err <= 1'b0;
         end
      end
   end

   always_comb begin
      o_ctrl = SEL_OTHER;
      case (r_state)
         ST_INTC_RD:   o_ctrl = SEL_INTC;
         ST_DISK_DONE: o_ctrl = SEL_DISK;
         default:      o_ctrl = SEL_OTHER;
      endcase
   end

   assign o_disk_rd  = (r_state == ST_DISK_WAIT);
   assign o_intc_rd  = (r_state == ST_INTC_RD);
   assign o_disk_err = r_disk_err;
   assign o_state    = r_state;

   // Combinational so the CPU freezes in the very cycle a request appears;
   // gated by reset so every output reads 0 while reset is held.
   assign o_stall = !i_reset && (i_disk_req || i_intc_req) &&
                    !(r_state == ST_INTC_RD || r_state == ST_DISK_DONE);

endmodule

// File: tb/tb_controlador_barramento_es.sv
// Self-checking bench for controlador_barramento_es (TIMEOUT_CYCLES=8).
// Stimulus pushes expected completions {select, disk_rd cycles, disk_err}
// into exp_q; a negedge monitor pops one entry whenever o_ctrl selects a
// source, and checks stall/strobe relations every cycle.
module tb_controlador_barramento_es;

   import controlador_barramento_es_pkg::*;

   localparam int T = 8;

   logic       i_clock = 1'b0;
   logic       i_reset;
   logic       i_disk_req;
   logic       i_intc_req;
   logic       i_disk_ack;
   logic       i_err_clr;
   logic [1:0] o_ctrl;
   logic       o_disk_rd;
   logic       o_intc_rd;
   logic       o_stall;
   logic       o_disk_err;
   logic [1:0] o_state;

   controlador_barramento_es #(.TIMEOUT_CYCLES(T), .CNT_W(8)) dut (
      .i_clock   (i_clock),
      .i_reset   (i_reset),
      .i_disk_req(i_disk_req),
      .i_intc_req(i_intc_req),
      .i_disk_ack(i_disk_ack),
      .i_err_clr (i_err_clr),
      .o_ctrl    (o_ctrl),
      .o_disk_rd (o_disk_rd),
      .o_intc_rd (o_intc_rd),
      .o_stall   (o_stall),
      .o_disk_err(o_disk_err),
      .o_state   (o_state)
   );

   always #5 i_clock = ~i_clock;

   int vectors     = 0;
   int miscompares = 0;
   logic [10:0] exp_q[$];
   int  ack_delay  = 100;
   int  ack_cnt    = 0;
   int  rd_cnt     = 0;
   bit  model_err  = 1'b0;
   bit  model_last_disk = 1'b1;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic tick();
      @(posedge i_clock);
      #1;
   endtask

   // Disk model: asserts ack in the ack_delay-th cycle of disk_rd; random
   // noise on ack whenever no disk read is in progress.
   initial begin
      i_disk_ack = 1'b0;
      forever begin
         @(posedge i_clock);
         #1;
         if (i_reset !== 1'b0) begin
            ack_cnt    = 0;
            i_disk_ack = 1'b0;
         end else if (o_disk_rd) begin
            ack_cnt++;
            i_disk_ack = (ack_cnt == ack_delay);
         end else begin
            ack_cnt    = 0;
            i_disk_ack = 1'($urandom_range(0, 1));
         end
      end
   end

   // Monitor
   initial begin
      logic [10:0] e;
      forever begin
         @(negedge i_clock);
         if (i_reset !== 1'b0) begin
            rd_cnt = 0;
         end else begin
            check("intc_rd_vs_ctrl", 32'(o_intc_rd), 32'(o_ctrl == SEL_INTC));
            check("stall", 32'(o_stall),
                  32'((i_disk_req || i_intc_req) && o_ctrl == SEL_OTHER));
            if (o_ctrl != SEL_OTHER) begin
               if (exp_q.size() == 0) begin
                  check("unexpected_grant", 32'(o_ctrl), 32'(SEL_OTHER));
               end else begin
                  e = exp_q.pop_front();
                  check("grant_src", 32'(o_ctrl), 32'(e[10:9]));
                  check("disk_rd_cycles", 32'(rd_cnt), 32'(e[8:1]));
                  check("disk_err_at_done", 32'(o_disk_err), 32'(e[0]));
               end
               rd_cnt = 0;
            end else if (o_disk_rd) begin
               rd_cnt++;
            end else begin
               rd_cnt = 0;
            end
         end
      end
   end

   function automatic logic [10:0] disk_entry(input int d);
      int n;
      n = (d <= T) ? d : T;
      if (d > T) model_err = 1'b1;
      return {SEL_DISK, 8'(n), model_err};
   endfunction

   // kind: 0 INTC only, 1 disk only, 2 both at once. d: ack delay in disk_rd
   // cycles (> T means never). hold_clr: err_clr held for the whole read.
   task automatic run_txn(input int kind, input int d, input bit hold_clr);
      bit intc_first;
      bit done;
      if (hold_clr) model_err = 1'b0;
      intc_first = (kind == 0) || (kind == 2 && model_last_disk);
      if (kind == 0) begin
         exp_q.push_back({SEL_INTC, 8'd0, model_err});
         model_last_disk = 1'b0;
      end else if (kind == 1) begin
         exp_q.push_back(disk_entry(d));
         model_last_disk = 1'b1;
      end else if (intc_first) begin
         exp_q.push_back({SEL_INTC, 8'd0, model_err});
         exp_q.push_back(disk_entry(d));
         model_last_disk = 1'b1;
      end else begin
         exp_q.push_back(disk_entry(d));
         exp_q.push_back({SEL_INTC, 8'd0, model_err});
         model_last_disk = 1'b0;
      end
      ack_delay  = d;
      i_err_clr  = hold_clr;
      i_intc_req = (kind != 1);
      i_disk_req = (kind != 0);
      done = 1'b0;
      for (int c = 0; c < 100; c++) begin
         tick();
         if (o_ctrl == SEL_INTC) i_intc_req = 1'b0;
         if (o_ctrl == SEL_DISK) i_disk_req = 1'b0;
         if (!i_intc_req && !i_disk_req) begin
            done = 1'b1;
            break;
         end
      end
      i_err_clr = 1'b0;
      if (!done) begin
         check("txn_timeout", 32'(done), 32'(1));
         i_intc_req = 1'b0;
         i_disk_req = 1'b0;
         tick();
         exp_q.delete();
      end
   endtask

   task automatic clear_err();
      i_err_clr = 1'b1;
      tick();
      i_err_clr = 1'b0;
      model_err = 1'b0;
      check("err_cleared", 32'(o_disk_err), 32'(0));
   endtask

   // Raise disk_req with no ack and return in the third disk_rd cycle.
   task automatic start_disk_wait3(output bit ok);
      int seen;
      seen = 0;
      ack_delay  = 100;
      i_disk_req = 1'b1;
      for (int c = 0; c < 20 && seen < 3; c++) begin
         tick();
         if (o_disk_rd) seen++;
      end
      ok = (seen == 3);
      check("reach_wait3", 32'(seen), 32'(3));
   endtask

   initial begin
      bit ok;
      i_reset    = 1'b1;
      i_disk_req = 1'b0;
      i_intc_req = 1'b0;
      i_err_clr  = 1'b0;

      // Reset with random inputs: every output held at 0.
      for (int i = 0; i < 4; i++) begin
         i_disk_req = 1'($urandom_range(0, 1));
         i_intc_req = 1'($urandom_range(0, 1));
         i_err_clr  = 1'($urandom_range(0, 1));
         tick();
         check("rst_ctrl", 32'(o_ctrl), 32'(0));
         check("rst_disk_rd", 32'(o_disk_rd), 32'(0));
         check("rst_intc_rd", 32'(o_intc_rd), 32'(0));
         check("rst_stall", 32'(o_stall), 32'(0));
         check("rst_disk_err", 32'(o_disk_err), 32'(0));
      end
      i_disk_req = 1'b0;
      i_intc_req = 1'b0;
      i_err_clr  = 1'b0;
      i_reset    = 1'b0;
      for (int i = 0; i < 3; i++) begin
         tick();
         check("idle_ctrl", 32'(o_ctrl), 32'(0));
         check("idle_state", 32'(o_state), 32'(ST_IDLE));
      end

      // Directed reads.
      run_txn(0, 0, 1'b0);     // INTC only
      tick();
      run_txn(1, 5, 1'b0);     // disk, ack in 5th wait cycle
      tick();
      run_txn(1, 100, 1'b0);   // timeout after T cycles, err set
      tick();
      run_txn(0, 0, 1'b0);     // err stays set
      tick();
      check("err_sticky", 32'(o_disk_err), 32'(1));
      clear_err();
      run_txn(1, T, 1'b0);     // ack in the expiry cycle: no error
      tick();
      run_txn(1, 100, 1'b1);   // timeout beats err_clr
      tick();
      check("err_timeout_wins", 32'(o_disk_err), 32'(1));
      clear_err();
      run_txn(2, 3, 1'b0);     // tie: INTC then disk
      tick();
      run_txn(2, 2, 1'b0);     // tie again: INTC then disk
      tick();

      // Flush in the third wait cycle.
      start_disk_wait3(ok);
      i_disk_req = 1'b0;
      model_last_disk = 1'b1;
      tick();
      check("flush_disk_rd", 32'(o_disk_rd), 32'(0));
      check("flush_state", 32'(o_state), 32'(ST_IDLE));
      check("flush_err", 32'(o_disk_err), 32'(model_err));
      tick();

      // Tie after a disk grant goes to INTC first.
      run_txn(2, 4, 1'b0);
      tick();

      // Asynchronous reset in the middle of a disk wait.
      start_disk_wait3(ok);
      #3;
      i_reset = 1'b1;
      #1;
      check("async_rst_disk_rd", 32'(o_disk_rd), 32'(0));
      check("async_rst_stall", 32'(o_stall), 32'(0));
      check("async_rst_ctrl", 32'(o_ctrl), 32'(0));
      check("async_rst_state", 32'(o_state), 32'(ST_IDLE));
      i_disk_req = 1'b0;
      tick();
      tick();
      i_reset = 1'b0;
      model_err = 1'b0;
      model_last_disk = 1'b1;
      tick();
      check("post_rst_state", 32'(o_state), 32'(ST_IDLE));

      // Randomised traffic.
      for (int n = 0; n < 60; n++) begin
         run_txn($urandom_range(0, 2), $urandom_range(1, 12), 1'b0);
         for (int g = 0, gl = $urandom_range(1, 3); g < gl; g++) tick();
         if ($urandom_range(0, 4) == 0) clear_err();
      end

      tick();
      tick();
      check("queue_drained", 32'(exp_q.size()), 32'(0));
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
